fft_output_reader: RTL and testbench

FFT_OUTPUT_READER -- requirements
Module: fft_output_reader

---
 rtl/fft_pkg.sv | 33 +++
 rtl/fft_out_skid_buf.sv | 78 +++++++
 rtl/fft_output_reader.sv | 170 +++++++++++++++++
 tb/tb_fft_output_reader.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
//   Shared constants and types for the FFT result-streaming logic.
//   - FFT_AWL_DEFAULT / FFT_DWL_DEFAULT : default address / component widths
//   - reader_state_e                    : reader FSM encoding (idle/read/drain)
//   - fft_eff_occ()                     : buffer slots committed for next cycle
// ---------------------------------------------------------------------------
package fft_pkg;

    localparam int unsigned FFT_AWL_DEFAULT = 5;
    localparam int unsigned FFT_DWL_DEFAULT = 16;

    // Depth of the output buffer; the read throttle is derived from this.
    localparam int unsigned FFT_OUT_BUF_DEPTH = 2;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRead  = 2'd1,
        StDrain = 2'd2
    } reader_state_e;

    // Slots that will be occupied at the start of next cycle if no new read
    // is issued now: current entries, minus the one leaving this cycle, plus
    // the read whose data lands in the buffer at the coming edge.
    function automatic logic [2:0] fft_eff_occ(
        input logic [1:0] count,
        input logic       pop,
        input logic       inflight
    );
        return {1'b0, count} - {2'b0, pop} + {2'b0, inflight};
    endfunction

endpackage

// File: rtl/fft_out_skid_buf.sv
// ---------------------------------------------------------------------------
// fft_out_skid_buf
//   Two-entry FIFO holding result samples plus their "last" tag between the
//   result-memory read port and the output stream.
//
//   Ports
//     CLK, RST          clock, synchronous active-high reset
//     push/data_in/     write one sample and its last tag
//       last_in
//     pop               remove the head entry (ignored when empty)
//     valid/data_out/   head entry; held stable until popped
//       last_out
//     count             current number of entries (0..2)
//
//   A push while full is dropped unless a pop happens in the same cycle; the
//   upstream throttle keeps that from ever occurring.
// ---------------------------------------------------------------------------
module fft_out_skid_buf
    import fft_pkg::*;
#(
    parameter int unsigned DWL = FFT_DWL_DEFAULT
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               push,
    input  logic [2*DWL-1:0]   data_in,
    input  logic               last_in,
    input  logic               pop,
    output logic               valid,
    output logic [2*DWL-1:0]   data_out,
    output logic               last_out,
    output logic [1:0]         count
);

    logic [2*DWL-1:0] r_data [2];
    logic [1:0]       r_last;
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;

    logic             w_do_pop;
    logic             w_do_push;

    assign w_do_pop  = pop && (r_count != 2'd0);
    // When full, a simultaneous pop frees the slot the write pointer targets.
    assign w_do_push = push && ((r_count != 2'd2) || w_do_pop);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_data[0] <= '0;
            r_data[1] <= '0;
            r_last    <= '0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_count   <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_data[r_wr_ptr] <= data_in;
                r_last[r_wr_ptr] <= last_in;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 2'd1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 2'd1;
            end
        end
    end

    assign valid    = (r_count != 2'd0);
    assign data_out = r_data[r_rd_ptr];
    assign last_out = r_last[r_rd_ptr];
    assign count    = r_count;

endmodule

// File: rtl/fft_output_reader.sv
// ---------------------------------------------------------------------------
// fft_output_reader
//   Streams a completed N = 2^AWL point transform out of the result memory as
//   a valid/ready stream of {re, im} samples, tagging the final sample.
//
//   Ports
//     CLK, RST          clock, synchronous active-high reset
//     START             one-cycle request; ignored unless idle
//     BUSY              high from the cycle after START until DONE
//     DONE              one-cycle pulse after the final output handshake
//     RD_EN/RD_ADDR     result-memory read strobe / address (0 when idle)
//     RD_DATA           read data, valid one cycle after RD_EN
//     OUT_VALID/        output stream; OUT_DATA and OUT_LAST hold while
//       OUT_READY/        OUT_VALID is high and OUT_READY is low
//       OUT_DATA/OUT_LAST
//
//   Configuration
//     FFT_OUT_BITREV_EN defined   : RD_ADDR is the bit-reversed read counter,
//                                   yielding natural order from an in-place
//                                   iterative FFT memory.
//     FFT_OUT_BITREV_EN undefined : RD_ADDR equals the read counter.
//
//   All outputs are forced to 0 while RST is high.
// ---------------------------------------------------------------------------
module fft_output_reader
    import fft_pkg::*;
#(
    parameter int unsigned AWL = FFT_AWL_DEFAULT,
    parameter int unsigned DWL = FFT_DWL_DEFAULT
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               START,
    output logic               BUSY,
    output logic               DONE,
    output logic               RD_EN,
    output logic [AWL-1:0]     RD_ADDR,
    input  logic [2*DWL-1:0]   RD_DATA,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic [2*DWL-1:0]   OUT_DATA,
    output logic               OUT_LAST
);

    localparam logic [AWL-1:0] LAST_CNT = '1;

    reader_state_e    r_state;
    reader_state_e    w_state_next;
    logic [AWL-1:0]   r_cnt;
    logic [AWL-1:0]   w_cnt_next;
    logic             r_inflight;
    logic             r_inflight_last;
    logic             r_done;

    logic             w_issue;
    logic             w_final_hs;
    logic             w_pop;
    logic [2:0]       w_occ;
    logic [AWL-1:0]   w_addr_map;

    logic             w_fifo_valid;
    logic [2*DWL-1:0] w_fifo_data;
    logic             w_fifo_last;
    logic [1:0]       w_fifo_count;

    // ------------------------------------------------------------------
    // Address mapping
    // ------------------------------------------------------------------
`ifdef FFT_OUT_BITREV_EN
    for (genvar gi = 0; gi < AWL; gi++) begin : g_bitrev
        assign w_addr_map[gi] = r_cnt[AWL-1-gi];
    end
`else
    assign w_addr_map = r_cnt;
`endif

    // ------------------------------------------------------------------
    // Output buffer
    // ------------------------------------------------------------------
    assign w_pop = w_fifo_valid && OUT_READY && !RST;

    // Read data returns one cycle after RD_EN, so the in-flight flag doubles
    // as the buffer push strobe and RD_DATA is written directly.
    fft_out_skid_buf #(
        .DWL (DWL)
    ) u_skid_buf (
        .CLK      (CLK),
        .RST      (RST),
        .push     (r_inflight),
        .data_in  (RD_DATA),
        .last_in  (r_inflight_last),
        .pop      (w_pop),
        .valid    (w_fifo_valid),
        .data_out (w_fifo_data),
        .last_out (w_fifo_last),
        .count    (w_fifo_count)
    );

    // Counting this cycle's pop lets a read issue into a slot being freed
    // now, which keeps the stream gap-free while OUT_READY stays high.
    assign w_occ = fft_eff_occ(w_fifo_count, w_pop, r_inflight);

    // ------------------------------------------------------------------
    // Reader FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_issue      = 1'b0;
        w_final_hs   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (START) begin
                    w_state_next = StRead;
                    w_cnt_next   = '0;
                end
            end
            StRead: begin
                if (w_occ < 3'(FFT_OUT_BUF_DEPTH)) begin
                    w_issue = 1'b1;
                    // Counter parks at N-1 rather than wrapping.
                    if (r_cnt == LAST_CNT) begin
                        w_state_next = StDrain;
                    end else begin
                        w_cnt_next = r_cnt + AWL'(1);
                    end
                end
            end
            StDrain: begin
                // The last-tagged sample is only ever pushed after leaving
                // StRead, so its handshake can only be seen here.
                if (w_pop && w_fifo_last) begin
                    w_state_next = StIdle;
                    w_final_hs   = 1'b1;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state         <= StIdle;
            r_cnt           <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_cnt           <= w_cnt_next;
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_cnt == LAST_CNT);
            r_done          <= w_final_hs;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign BUSY      = (r_state != StIdle) && !RST;
    assign DONE      = r_done && !RST;
    assign RD_EN     = w_issue && !RST;
    assign RD_ADDR   = RD_EN ? w_addr_map : '0;
    assign OUT_VALID = w_fifo_valid && !RST;
    assign OUT_DATA  = OUT_VALID ? w_fifo_data : '0;
    assign OUT_LAST  = OUT_VALID && w_fifo_last;

endmodule

// File: tb/tb_fft_output_reader.sv
// Self-checking bench for fft_output_reader with AWL=3 (N=8), DWL=16.
// The expected stream is built from a random memory image and the address
// order (natural or bit-reversed, following FFT_OUT_BITREV_EN).
module tb_fft_output_reader;

    localparam int unsigned AWL = 3;
    localparam int unsigned DWL = 16;
    localparam int unsigned N   = 1 << AWL;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               busy;
    logic               done;
    logic               rd_en;
    logic [AWL-1:0]     rd_addr;
    logic [2*DWL-1:0]   rd_data;
    logic               out_valid;
    logic               out_ready;
    logic [2*DWL-1:0]   out_data;
    logic               out_last;

    fft_output_reader #(
        .AWL (AWL),
        .DWL (DWL)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .START     (start),
        .BUSY      (busy),
        .DONE      (done),
        .RD_EN     (rd_en),
        .RD_ADDR   (rd_addr),
        .RD_DATA   (rd_data),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .OUT_DATA  (out_data),
        .OUT_LAST  (out_last)
    );

    always #5 clk = ~clk;

    // Result memory: one-cycle read latency, junk when not reading.
    logic [2*DWL-1:0] mem [N];
    always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : 32'($urandom());

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Address the k-th read must use.
    function automatic int unsigned ref_addr(input int unsigned k);
        int unsigned r;
        r = k;
`ifdef FFT_OUT_BITREV_EN
        r = 0;
        for (int b = 0; b < AWL; b++) begin
            if (((k >> b) & 1) != 0) r = r | (1 << (AWL - 1 - b));
        end
`endif
        return r;
    endfunction

    // Scoreboard.
    logic [2*DWL-1:0] exp_data [$];
    bit               exp_last [$];
    int unsigned      n_rd;
    int unsigned      n_hs   = 0;
    int unsigned      n_done = 0;

    // Snapshot of DUT outputs taken at the falling edge of each cycle.
    logic             s_busy, s_done, s_rd_en, s_valid, s_last;
    logic [AWL-1:0]   s_rd_addr;
    logic [2*DWL-1:0] s_data;
    logic             prev_stall   = 1'b0;
    logic [2*DWL-1:0] prev_data    = '0;
    logic             prev_last    = 1'b0;
    logic             prev_last_hs = 1'b0;

    task automatic load_transfer();
        exp_data.delete();
        exp_last.delete();
        for (int i = 0; i < N; i++) mem[i] = 32'($urandom());
        for (int k = 0; k < N; k++) begin
            exp_data.push_back(mem[ref_addr(k)]);
            exp_last.push_back(k == N - 1);
        end
        n_rd = 0;
    endtask

    // Inputs are set by the caller just after a rising edge; this samples at
    // the falling edge, checks stream rules, then moves past the next rise.
    task automatic cycle();
        logic hs;
        @(negedge clk);
        s_busy    = busy;
        s_done    = done;
        s_rd_en   = rd_en;
        s_rd_addr = rd_addr;
        s_valid   = out_valid;
        s_data    = out_data;
        s_last    = out_last;
        if (prev_stall && !rst) begin
            check("hold_data", s_data, prev_data);
            check("hold_last", s_last, prev_last);
        end
        if (s_rd_en) begin
            if (n_rd < N) check("rd_addr", s_rd_addr, ref_addr(n_rd));
            else          check("read_count", n_rd, N - 1);
            n_rd++;
        end else begin
            check("rd_addr_idle", s_rd_addr, 0);
        end
        if (s_done) begin
            n_done++;
            check("done_after_last", prev_last_hs, 1);
        end
        hs = s_valid && out_ready;
        if (hs) begin
            if (exp_data.size() == 0) begin
                check("extra_sample", exp_data.size(), 1);
            end else begin
                check("out_data", s_data, exp_data.pop_front());
                check("out_last", s_last, exp_last.pop_front());
            end
            n_hs++;
        end
        prev_stall   = s_valid && !out_ready;
        prev_data    = s_data;
        prev_last    = s_last;
        prev_last_hs = hs && s_last;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  s_busy,    0);
        check({tag, "_done"},  s_done,    0);
        check({tag, "_rd_en"}, s_rd_en,   0);
        check({tag, "_addr"},  s_rd_addr, 0);
        check({tag, "_valid"}, s_valid,   0);
        check({tag, "_data"},  s_data,    0);
        check({tag, "_last"},  s_last,    0);
    endtask

    // mode 0: ready high; 1: ready random 50%; 2: ready low in cycles 3-8;
    // 3: ready high with a second START pulse during READ.
    function automatic logic ready_for(input int mode, input int c);
        if (mode == 1) return logic'($urandom_range(0, 1));
        if (mode == 2) return !(c >= 3 && c <= 8);
        return 1'b1;
    endfunction

    task automatic run_transfer(input int mode);
        int          done_cyc;
        int unsigned hs0, done0, stall_reads;
        load_transfer();
        hs0         = n_hs;
        done0       = n_done;
        done_cyc    = -1;
        stall_reads = 0;
        start       = 1'b1;
        out_ready   = ready_for(mode, 0);
        cycle();
        check("busy_c0", s_busy, 0);
        start = 1'b0;
        for (int c = 1; c < 300; c++) begin
            start     = (mode == 3) && (c == 4);
            out_ready = ready_for(mode, c);
            cycle();
            if (mode == 2 && c <= 8 && s_rd_en) stall_reads++;
            if (mode == 0) begin
                check("tbl_busy",  s_busy,    (c >= 1 && c <= 10));
                check("tbl_rd_en", s_rd_en,   (c >= 1 && c <= 8));
                check("tbl_addr",  s_rd_addr, (c >= 1 && c <= 8) ? ref_addr(c - 1) : 0);
                check("tbl_valid", s_valid,   (c >= 3 && c <= 10));
                check("tbl_last",  s_last,    (c == 10));
                check("tbl_done",  s_done,    (c == 11));
            end
            if (s_done) begin
                done_cyc = c;
                break;
            end
        end
        check("done_seen",   done_cyc != -1, 1);
        check("samples",     n_hs - hs0, N);
        check("done_count",  n_done - done0, 1);
        check("queue_empty", exp_data.size(), 0);
        check("reads",       n_rd, N);
        if (mode == 0 || mode == 3) check("done_cycle", done_cyc, 11);
        if (mode == 2) check("stall_reads_le2", stall_reads <= 2, 1);
        out_ready = 1'b1;
        cycle();
        check("busy_after", s_busy, 0);
    endtask

    task automatic run_abort();
        int unsigned done0;
        load_transfer();
        done0     = n_done;
        start     = 1'b1;
        out_ready = 1'b1;
        cycle();
        start = 1'b0;
        for (int c = 1; c <= 4; c++) cycle();
        rst = 1'b1;
        cycle();
        check_all_zero("abort_rst");
        rst = 1'b0;
        exp_data.delete();
        exp_last.delete();
        cycle();
        check_all_zero("abort_next");
        for (int c = 0; c < 6; c++) cycle();
        check("abort_no_done", n_done - done0, 0);
        check("abort_idle_valid", s_valid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) cycle();
        check_all_zero("reset");
        rst = 1'b0;

        run_transfer(0);  // START in the first cycle after reset
        run_transfer(2);
        run_transfer(3);
        run_abort();
        run_transfer(0);
        for (int t = 0; t < 25; t++) run_transfer(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
